// File: rtl/sram_ecc_bank_pkg.sv
// Shared sizing for the packet-buffer bank and the Hamming position map of a 128-bit page.
// Page bit k sits at the (k+1)-th non-power-of-two position, leaving powers of two for check bits.
package sram_ecc_bank_pkg;

  localparam int SRAM_DEPTH = 16384;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 16;
  localparam int PAGE_W     = 11;
  localparam int WORD_W     = 3;
  localparam int ECC_W      = 8;
  localparam int PAGE_BITS  = DATA_W << WORD_W;

  function automatic logic [ECC_W-1:0] hpos(input int k);
    int               cnt;
    logic [ECC_W-1:0] r;
    cnt = 0;
    r   = '0;
    for (int n = 1; n <= PAGE_BITS + ECC_W; n++) begin
      if ((n & (n - 1)) != 0) begin
        if (cnt == k) r = ECC_W'(n);
        cnt++;
      end
    end
    return r;
  endfunction

  // Set of page bits that feed check bit i.
  function automatic logic [PAGE_BITS-1:0] chk_mask(input int i);
    logic [PAGE_BITS-1:0] m;
    logic [ECC_W-1:0]     p;
    m = '0;
    for (int k = 0; k < PAGE_BITS; k++) begin
      p = hpos(k);
      if (((int'(p) >> i) & 1) != 0) m = m | (PAGE_BITS'(1) << k);
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_ecc_bank_enc.sv
// Combinational Hamming check-code generator over one 8-word page; zero latency.
// No backpressure: pure logic, no clock.
module sram_ecc_bank_enc
  import sram_ecc_bank_pkg::*;
(
  input  logic [DATA_W-1:0] enc_data_0,
  input  logic [DATA_W-1:0] enc_data_1,
  input  logic [DATA_W-1:0] enc_data_2,
  input  logic [DATA_W-1:0] enc_data_3,
  input  logic [DATA_W-1:0] enc_data_4,
  input  logic [DATA_W-1:0] enc_data_5,
  input  logic [DATA_W-1:0] enc_data_6,
  input  logic [DATA_W-1:0] enc_data_7,
  output logic [ECC_W-1:0]  enc_code
);

  logic [PAGE_BITS-1:0] page;

  assign page = {enc_data_7, enc_data_6, enc_data_5, enc_data_4,
                 enc_data_3, enc_data_2, enc_data_1, enc_data_0};

  for (genvar i = 0; i < ECC_W; i++) begin : g_chk
    localparam logic [PAGE_BITS-1:0] MASK = chk_mask(i);
    assign enc_code[i] = ^(page & MASK);
  end

endmodule

// File: rtl/sram_ecc_bank_mem.sv
// 16K x 16 single-write/single-read array; read data registered, 1-cycle latency, read-first.
// No backpressure: both ports accept a strobe every cycle.
module sram_ecc_bank_mem
  import sram_ecc_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [SRAM_DEPTH];
  logic [DATA_W-1:0] dout_d, dout_q;

  // The array itself is never reset; only the output register is.
  always_comb begin
    dout_d = dout_q;
    if (!rst_n) begin
      dout_d = '0;
    end else if (rd_en) begin
      dout_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    dout_q <= dout_d;
    if (rst_n && wr_en) begin
      mem[wr_addr] <= din;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/sram_ecc_bank.sv
// Packet-buffer storage bank: registered-read SRAM (1-cycle) plus combinational page ECC encoder.
// No backpressure: reads and writes may issue every cycle.
module sram_ecc_bank
  import sram_ecc_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] dout,
  input  logic [DATA_W-1:0] enc_data_0,
  input  logic [DATA_W-1:0] enc_data_1,
  input  logic [DATA_W-1:0] enc_data_2,
  input  logic [DATA_W-1:0] enc_data_3,
  input  logic [DATA_W-1:0] enc_data_4,
  input  logic [DATA_W-1:0] enc_data_5,
  input  logic [DATA_W-1:0] enc_data_6,
  input  logic [DATA_W-1:0] enc_data_7,
  output logic [ECC_W-1:0]  enc_code
);

  sram_ecc_bank_mem u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .din     (din),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .dout    (dout)
  );

  sram_ecc_bank_enc u_enc (
    .enc_data_0 (enc_data_0),
    .enc_data_1 (enc_data_1),
    .enc_data_2 (enc_data_2),
    .enc_data_3 (enc_data_3),
    .enc_data_4 (enc_data_4),
    .enc_data_5 (enc_data_5),
    .enc_data_6 (enc_data_6),
    .enc_data_7 (enc_data_7),
    .enc_code   (enc_code)
  );

endmodule

// File: tb/tb_sram_ecc_bank.sv
// Directed and randomized bench for sram_ecc_bank: memory against an array model,
// encoder against a codeword-position model built by counting non-power-of-two slots.
module tb_sram_ecc_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [15:0] din;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic [15:0] dout;
  logic [127:0] enc_page;
  logic [7:0]   enc_code;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [16384];
  logic [15:0] exp_dout;
  int          pos_of [128];

  always #5 clk = ~clk;

  sram_ecc_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .din        (din),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .dout       (dout),
    .enc_data_0 (enc_page[15:0]),
    .enc_data_1 (enc_page[31:16]),
    .enc_data_2 (enc_page[47:32]),
    .enc_data_3 (enc_page[63:48]),
    .enc_data_4 (enc_page[79:64]),
    .enc_data_5 (enc_page[95:80]),
    .enc_data_6 (enc_page[111:96]),
    .enc_data_7 (enc_page[127:112]),
    .enc_code   (enc_code)
  );

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bank cycle out of reset; the model resolves read-first before applying the write.
  task automatic cyc(input string tag, input logic we, input logic [13:0] wa, input logic [15:0] d,
                     input logic re, input logic [13:0] ra);
    wr_en   = we;
    wr_addr = wa;
    din     = d;
    rd_en   = re;
    rd_addr = ra;
    if (re) exp_dout = model[ra];
    if (we) model[wa] = d;
    step();
    check16(tag, dout, exp_dout);
  endtask

  function automatic logic [7:0] ref_code(input logic [127:0] d);
    logic [7:0] c;
    c = '0;
    for (int k = 0; k < 128; k++) begin
      if (d[k]) c = c ^ 8'(pos_of[k]);
    end
    return c;
  endfunction

  task automatic enc_eval(input logic [127:0] d, output logic [7:0] c);
    enc_page = d;
    #1;
    c = enc_code;
  endtask

  initial begin
    int          cnt;
    logic [7:0]  ca, cb, cab, stored, syn;
    logic [127:0] pa, pb;
    logic [13:0] wa, ra;
    int          kb;

    cnt = 0;
    for (int n = 1; cnt < 128; n++) begin
      if ((n & (n - 1)) != 0) begin
        pos_of[cnt] = n;
        cnt++;
      end
    end

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; din = '0;
    rd_en = 1'b0; rd_addr = '0; enc_page = '0;
    exp_dout = 16'h0000;
    repeat (2) step();
    check16("reset_dout", dout, 16'h0000);
    rst_n = 1'b1;

    cyc("wr0",        1'b1, 14'h0000, 16'hABCD, 1'b0, 14'h0000);
    cyc("wr3fff",     1'b1, 14'h3FFF, 16'h1234, 1'b0, 14'h0000);
    cyc("rd0",        1'b0, 14'h0000, 16'h0000, 1'b1, 14'h0000);
    check16("rd0_abs", dout, 16'hABCD);
    cyc("rd3fff",     1'b0, 14'h0000, 16'h0000, 1'b1, 14'h3FFF);
    check16("rd3fff_abs", dout, 16'h1234);

    cyc("wr100",      1'b1, 14'h0100, 16'hAAAA, 1'b0, 14'h0000);
    cyc("rw_same",    1'b1, 14'h0100, 16'h5555, 1'b1, 14'h0100);
    check16("read_first_abs", dout, 16'hAAAA);
    cyc("rd_after_rw", 1'b0, 14'h0000, 16'h0000, 1'b1, 14'h0100);
    check16("rd_after_rw_abs", dout, 16'h5555);
    cyc("hold",       1'b0, 14'h0000, 16'h0000, 1'b0, 14'h0100);

    cyc("wr_beef",    1'b1, 14'h0200, 16'hBEEF, 1'b0, 14'h0000);
    cyc("rd_beef",    1'b0, 14'h0000, 16'h0000, 1'b1, 14'h0200);
    check16("rd_beef_abs", dout, 16'hBEEF);
    // Strobes during reset must be dropped, including a write over the stored value.
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 14'h0200; din = 16'h1111;
    rd_en = 1'b1; rd_addr = 14'h0200;
    step();
    check16("mid_reset_dout", dout, 16'h0000);
    rst_n = 1'b1;
    exp_dout = 16'h0000;
    cyc("rd_after_reset", 1'b0, 14'h0000, 16'h0000, 1'b1, 14'h0200);
    check16("rd_after_reset_abs", dout, 16'hBEEF);

    for (int i = 0; i < 64; i++) begin
      cyc("preload", 1'b1, 14'(14'h2000 + i), 16'($urandom), 1'b0, 14'h0000);
    end
    for (int i = 0; i < 400; i++) begin
      wa = 14'(14'h2000 + $urandom_range(0, 63));
      ra = 14'(14'h2000 + $urandom_range(0, 63));
      cyc("rand_rw", 1'($urandom_range(0, 1)), wa, 16'($urandom), 1'($urandom_range(0, 1)), ra);
    end
    wr_en = 1'b0; rd_en = 1'b0;

    enc_eval(128'h0, ca);
    check8("enc_zero", ca, 8'h00);
    enc_eval(128'h1, ca);
    check8("enc_d0_1", ca, 8'h03);
    enc_eval(128'h2, ca);
    check8("enc_d0_2", ca, 8'h05);
    enc_eval(128'h3, ca);
    check8("enc_d0_3", ca, 8'h06);
    enc_eval({16'h8000, 112'h0}, ca);
    check8("enc_d7_8000", ca, 8'h88);

    for (int i = 0; i < 1000; i++) begin
      pa = {$urandom, $urandom, $urandom, $urandom};
      pb = {$urandom, $urandom, $urandom, $urandom};
      enc_eval(pa, ca);
      enc_eval(pb, cb);
      enc_eval(pa ^ pb, cab);
      check8("enc_linear", cab, ca ^ cb);
      if (i % 10 == 0) check8("enc_model", ca, ref_code(pa));
    end

    for (int i = 0; i < 200; i++) begin
      pa = {$urandom, $urandom, $urandom, $urandom};
      enc_eval(pa, stored);
      kb = int'($urandom_range(0, 127));
      enc_eval(pa ^ (128'(1) << kb), syn);
      check8("enc_syndrome", syn ^ stored, 8'(pos_of[kb]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
